// File: rtl/systolic_seq_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the systolic instruction sequencer.
package systolic_seq_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOAD_W  = 4'h1;
  localparam logic [3:0] OP_LOAD_IN = 4'h2;
  localparam logic [3:0] OP_COMPUTE = 4'h3;
  localparam logic [3:0] OP_STORE   = 4'h4;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam int OPCODE_LSB = 60;
  localparam int ADDR_LSB   = 44;
  localparam int LEN_LSB    = 32;
  localparam int RSVD_MSB   = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD_W,
    S_LOAD_IN,
    S_COMPUTE,
    S_DRAIN,
    S_STORE,
    S_HALTED
  } seqState_e;

  // A full diagonal flush of an N x N array takes 2N-1 cycles.
  function automatic int DRAIN_CYCLES(input int arrayDim);
    return 2 * arrayDim - 1;
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable down-counter; done_o marks the final cycle of the phase being counted.
module seq_phase_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= loadVal_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/systolic_instr_sequencer.sv
// Fetches one instruction at a time and steps the systolic array through load/compute/drain/store.
// Optional performance counters are enabled with the SEQ_PERF_CNT_EN macro.
module systolic_instr_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int ARRAY_DIM = 8,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [63:0]       instr_in,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              weight_load_en,
  output logic              act_load_en,
  output logic              compute_en,
  output logic              drain_en,
  output logic              store_en,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_compute_cycles,
  output logic [15:0]       perf_instr_count
`endif
);

  localparam int CNT_W = (LEN_W > $clog2(2 * ARRAY_DIM)) ? LEN_W : $clog2(2 * ARRAY_DIM);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES(ARRAY_DIM));
  localparam logic [CNT_W-1:0] DIM_LOAD   = CNT_W'(ARRAY_DIM);

  seqState_e         state_q;
  logic [3:0]        opcode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic              weightEn_q, actEn_q, computeEn_q, drainEn_q, storeEn_q;
  logic              halted_q, errIllegal_q;

  logic              cntLoad, cntDec, cntDone;
  logic [CNT_W-1:0]  cntLoadVal;
  logic              opLegal, lenZero;
  logic              unusedReserved;

  assign unusedReserved = ^instr_in[RSVD_MSB:0];
  assign opLegal = opcode_q inside {OP_NOP, OP_LOAD_W, OP_LOAD_IN, OP_COMPUTE, OP_STORE, OP_HALT};
  assign lenZero = (len_q == '0);

  // The counter is armed in DECODE and re-armed with the drain length when compute finishes.
  always_comb begin
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = CNT_W'(len_q);
    case (state_q)
      S_DECODE: begin
        cntLoad = 1'b1;
        if ((opcode_q == OP_LOAD_W) && (CNT_W'(len_q) > DIM_LOAD)) cntLoadVal = DIM_LOAD;
      end
      S_COMPUTE: begin
        if (cntDone) begin
          cntLoad    = 1'b1;
          cntLoadVal = DRAIN_LOAD;
        end else begin
          cntDec = 1'b1;
        end
      end
      S_LOAD_W, S_LOAD_IN, S_STORE, S_DRAIN: cntDec = 1'b1;
      default: ;
    endcase
  end

  seq_phase_counter #(.CNT_W(CNT_W)) u_phaseCnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cntLoad),
    .loadVal_i(cntLoadVal),
    .dec_i    (cntDec),
    .done_o   (cntDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      memAddr_q    <= '0;
      weightEn_q   <= 1'b0;
      actEn_q      <= 1'b0;
      computeEn_q  <= 1'b0;
      drainEn_q    <= 1'b0;
      storeEn_q    <= 1'b0;
      halted_q     <= 1'b0;
      errIllegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            opcode_q <= instr_in[OPCODE_LSB +: 4];
            addr_q   <= instr_in[ADDR_LSB +: ADDR_W];
            len_q    <= instr_in[LEN_LSB +: LEN_W];
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!opLegal) begin
            errIllegal_q <= 1'b1;
            state_q      <= S_IDLE;
          end else if (opcode_q == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALTED;
          end else if ((opcode_q == OP_NOP) || lenZero) begin
            state_q <= S_IDLE;
          end else begin
            memAddr_q <= addr_q;
            case (opcode_q)
              OP_LOAD_W:  begin weightEn_q  <= 1'b1; state_q <= S_LOAD_W;  end
              OP_LOAD_IN: begin actEn_q     <= 1'b1; state_q <= S_LOAD_IN; end
              OP_COMPUTE: begin computeEn_q <= 1'b1; state_q <= S_COMPUTE; end
              default:    begin storeEn_q   <= 1'b1; state_q <= S_STORE;   end
            endcase
          end
        end
        S_LOAD_W, S_LOAD_IN, S_STORE: begin
          memAddr_q <= memAddr_q + ADDR_W'(1);
          if (cntDone) begin
            weightEn_q <= 1'b0;
            actEn_q    <= 1'b0;
            storeEn_q  <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_COMPUTE: begin
          if (cntDone) begin
            computeEn_q <= 1'b0;
            drainEn_q   <= 1'b1;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cntDone) begin
            drainEn_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_HALTED: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready    = (state_q == S_IDLE) && !halted_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign mem_addr       = memAddr_q;
  assign weight_load_en = weightEn_q;
  assign act_load_en    = actEn_q;
  assign compute_en     = computeEn_q;
  assign drain_en       = drainEn_q;
  assign store_en       = storeEn_q;
  assign halted         = halted_q;
  assign err_illegal    = errIllegal_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perfCycles_q;
  logic [15:0] perfInstr_q;
  logic        retire;

  // Dropped illegal instructions never retire; NOP/HALT retire straight from DECODE.
  assign retire = ((state_q == S_DECODE) && opLegal &&
                   ((opcode_q == OP_NOP) || (opcode_q == OP_HALT) || lenZero)) ||
                  (cntDone && (state_q inside {S_LOAD_W, S_LOAD_IN, S_STORE, S_DRAIN}));

  always_ff @(posedge clk) begin
    if (rst) begin
      perfCycles_q <= '0;
      perfInstr_q  <= '0;
    end else begin
      if ((computeEn_q || drainEn_q) && (perfCycles_q != 32'hFFFF_FFFF)) begin
        perfCycles_q <= perfCycles_q + 32'd1;
      end
      if (retire) perfInstr_q <= perfInstr_q + 16'd1;
    end
  end

  assign perf_compute_cycles = perfCycles_q;
  assign perf_instr_count    = perfInstr_q;
`endif

endmodule

// File: tb/tb_systolic_instr_sequencer.sv
// Scoreboard bench: stimulus pushes the expected enable pulses, a negedge monitor pops and compares them.
module tb_systolic_instr_sequencer;

  localparam int ARRAY_DIM = 8;
  localparam int ADDR_W    = 16;
  localparam int LEN_W     = 12;

  localparam logic [4:0] EN_W = 5'b10000;
  localparam logic [4:0] EN_A = 5'b01000;
  localparam logic [4:0] EN_C = 5'b00100;
  localparam logic [4:0] EN_D = 5'b00010;
  localparam logic [4:0] EN_S = 5'b00001;

  typedef struct {
    logic [4:0]  en;
    logic [15:0] addr;
    bit          chkAddr;
    int          cyc;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic [63:0]       instr_in;
  logic              instr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              weight_load_en, act_load_en, compute_en, drain_en, store_en;
  logic              busy, halted, err_illegal;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]       perf_compute_cycles;
  logic [15:0]       perf_instr_count;
`endif

  int  testsRun    = 0;
  int  testsFailed = 0;
  int  cycleCount  = 0;
  bit  expErr      = 1'b0;
  ev_t expQ[$];

  systolic_instr_sequencer #(
    .ARRAY_DIM(ARRAY_DIM),
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
    .instr_ready   (instr_ready),
    .mem_addr      (mem_addr),
    .weight_load_en(weight_load_en),
    .act_load_en   (act_load_en),
    .compute_en    (compute_en),
    .drain_en      (drain_en),
    .store_en      (store_en),
    .busy          (busy),
    .halted        (halted),
    .err_illegal   (err_illegal)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_compute_cycles(perf_compute_cycles),
    .perf_instr_count   (perf_instr_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Reference model: the enable pulses each instruction must produce, stamped with their cycle.
  task automatic pushModel(input logic [3:0] op, input logic [15:0] addr, input int len, input int c);
    int n;
    if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15})) begin
      expErr = 1'b1;
      return;
    end
    if (op == 4'd0 || op == 4'd15 || len == 0) return;
    case (op)
      4'd1: begin
        n = (len < ARRAY_DIM) ? len : ARRAY_DIM;
        for (int i = 0; i < n; i++) expQ.push_back('{EN_W, 16'(addr + i), 1'b1, c + 2 + i});
      end
      4'd2: for (int i = 0; i < len; i++) expQ.push_back('{EN_A, 16'(addr + i), 1'b1, c + 2 + i});
      4'd4: for (int i = 0; i < len; i++) expQ.push_back('{EN_S, 16'(addr + i), 1'b1, c + 2 + i});
      default: begin
        for (int i = 0; i < len; i++) expQ.push_back('{EN_C, 16'h0, 1'b0, c + 2 + i});
        for (int j = 0; j < 2 * ARRAY_DIM - 1; j++)
          expQ.push_back('{EN_D, 16'h0, 1'b0, c + 2 + len + j});
      end
    endcase
  endtask

  task automatic toNeg(input int target);
    @(negedge clk);
    while (cycleCount < target) @(negedge clk);
  endtask

  task automatic toPos(input int target);
    do begin
      @(posedge clk);
      #1;
    end while (cycleCount < target);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] addr, input logic [11:0] len,
                               output int hs);
    int waited = 0;
    hs = -1;
    @(posedge clk);
    #1;
    instr_in    = {op, addr, len, 32'($urandom())};
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!instr_ready && waited < 400);
    if (!instr_ready) begin
      checkOutput("handshake_timeout", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    hs = cycleCount;
    pushModel(op, addr, int'(len), hs);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("err_illegal", {31'd0, err_illegal}, {31'd0, expErr});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_enables"}, {27'd0, weight_load_en, act_load_en, compute_en, drain_en, store_en}, 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err_illegal}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [4:0] en;
    ev_t        e;
    en = {weight_load_en, act_load_en, compute_en, drain_en, store_en};
    if (en != 5'd0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_enable", {27'd0, en}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("enable_kind", {27'd0, en}, {27'd0, e.en});
        checkOutput("enable_cycle", 32'(cycleCount), 32'(e.cyc));
        if (e.chkAddr) checkOutput("mem_addr", 32'(mem_addr), {16'd0, e.addr});
        checkOutput("busy_in_phase", {31'd0, busy}, 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int r;
    logic [3:0]  op;
    logic [11:0] len;
    logic [15:0] addr;

    rst = 1'b1;
    instr_valid = 1'b0;
    instr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset");

    applyStimulus(4'd1, 16'h0100, 12'd3, hs);
    toNeg(hs + 5);
    checkOutput("loadw_ready_after", {31'd0, instr_ready}, 32'd1);
    checkOutput("loadw_busy_after", {31'd0, busy}, 32'd0);

    applyStimulus(4'd3, 16'h0300, 12'd5, hs);
    toNeg(hs + 21);
    checkOutput("drain_last_busy", {31'd0, busy}, 32'd1);
    toNeg(hs + 22);
    checkOutput("compute_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("compute_idle_ready", {31'd0, instr_ready}, 32'd1);

    applyStimulus(4'd4, 16'hFFFE, 12'd4, hs);
    toNeg(hs + 6);
    checkOutput("store_ready_after", {31'd0, instr_ready}, 32'd1);

    applyStimulus(4'd7, 16'h1234, 12'd5, hs);
    applyStimulus(4'd2, 16'h0040, 12'd2, hs);
    toNeg(hs + 5);
    checkOutput("loadin_queue_empty", 32'(expQ.size()), 32'd0);

    applyStimulus(4'd1, 16'h0500, 12'd20, hs);
    toNeg(hs + 10);
    checkOutput("loadw_clamp_ready", {31'd0, instr_ready}, 32'd1);
    applyStimulus(4'd0, 16'h0600, 12'd5, hs);
    checkOutput("nop_ready", {31'd0, instr_ready}, 32'd1);
    applyStimulus(4'd4, 16'h0700, 12'd0, hs);
    checkOutput("len0_ready", {31'd0, instr_ready}, 32'd1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 6);
      if (r <= 4) op = 4'(r);
      else if (r == 5) op = 4'($urandom_range(5, 14));
      else op = 4'd1;
      len  = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 24));
      addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom());
      applyStimulus(op, addr, len, hs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int k = 0; k < 300 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("random_queue_drained", 32'(expQ.size()), 32'd0);

    applyStimulus(4'd3, 16'h0200, 12'd10, hs);
    toPos(hs + 4);
    rst = 1'b1;
    toPos(hs + 5);
    expQ.delete();
    expErr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkIdle("rst_mid_compute");
    toNeg(hs + 30);

    applyStimulus(4'd15, 16'h0000, 12'd0, hs);
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    instr_in    = {4'd1, 16'h0800, 12'd4, 32'h0};
    instr_valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checkOutput("halt_ready_low", {31'd0, instr_ready}, 32'd0);
    end
    checkOutput("halt_sticky", {31'd0, halted}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdle("post_halt_rst");

    applyStimulus(4'd1, 16'h0020, 12'd2, hs);
    toNeg(hs + 5);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
